multdiv_ctrl: RTL

// Sequencer between the pipeline and the multiply/divide cores: latches operands on a

---
 rtl/multdiv_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/multdiv_ctrl.sv
// Sequencer between the pipeline and the multiply/divide cores: latches operands,
// starts the selected core, waits for done (or watchdog) and reports one result pulse.
module multdiv_ctrl #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 40
) (
  input  logic                 clk,
  input  logic                 clr_n,
  input  logic [WIDTH-1:0]     data_operandA,
  input  logic [WIDTH-1:0]     data_operandB,
  input  logic                 ctrl_MULT,
  input  logic                 ctrl_DIV,
  output logic [WIDTH-1:0]     data_result,
  output logic                 data_exception,
  output logic                 data_resultRDY,
  output logic                 busy,
  output logic                 mult_start,
  output logic [WIDTH-1:0]     mult_A,
  output logic [WIDTH-1:0]     mult_B,
  input  logic [2*WIDTH-1:0]   mult_product,
  input  logic                 mult_done,
  output logic                 div_start,
  output logic [WIDTH-1:0]     div_dividend,
  output logic [WIDTH-1:0]     div_divisor,
  input  logic [WIDTH-1:0]     div_quotient,
  input  logic                 div_done
);

  localparam int unsigned WDW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MSTART,
    S_MRUN,
    S_DSTART,
    S_DRUN,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             exc_q, exc_d;
  logic [WDW-1:0]   wdog_q, wdog_d;
  logic             rdy_q, rdy_d;
  logic             busy_q, busy_d;
  logic             mstart_q, mstart_d;
  logic             dstart_q, dstart_d;

  logic [WIDTH:0]   prod_hi_c;
  logic             ovf_c;
  logic             wdog_exp_c;

  // Product fits in WIDTH signed bits only if the upper half plus sign bit is uniform
  assign prod_hi_c  = mult_product[2*WIDTH-1:WIDTH-1];
  assign ovf_c      = !((prod_hi_c == '0) || (&prod_hi_c));
  assign wdog_exp_c = (wdog_q == WDW'(TIMEOUT - 1));

  // Next state; a new command always wins, aborting any op in flight
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    wdog_d   = wdog_q;
    result_d = result_q;
    exc_d    = exc_q;
    if (ctrl_MULT) begin
      a_d     = data_operandA;
      b_d     = data_operandB;
      state_d = S_MSTART;
    end else if (ctrl_DIV) begin
      a_d = data_operandA;
      b_d = data_operandB;
      if (data_operandB == '0) begin
        result_d = '0;
        exc_d    = 1'b1;
        state_d  = S_DONE;
      end else begin
        state_d = S_DSTART;
      end
    end else begin
      case (state_q)
        S_MSTART: begin
          wdog_d  = '0;
          state_d = S_MRUN;
        end
        S_DSTART: begin
          wdog_d  = '0;
          state_d = S_DRUN;
        end
        S_MRUN: begin
          if (mult_done) begin
            result_d = mult_product[WIDTH-1:0];
            exc_d    = ovf_c;
            state_d  = S_DONE;
          end else if (wdog_exp_c) begin
            result_d = '0;
            exc_d    = 1'b1;
            state_d  = S_DONE;
          end else begin
            wdog_d = WDW'(wdog_q + 1'b1);
          end
        end
        S_DRUN: begin
          if (div_done) begin
            result_d = div_quotient;
            exc_d    = 1'b0;
            state_d  = S_DONE;
          end else if (wdog_exp_c) begin
            result_d = '0;
            exc_d    = 1'b1;
            state_d  = S_DONE;
          end else begin
            wdog_d = WDW'(wdog_q + 1'b1);
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
    mstart_d = (state_d == S_MSTART);
    dstart_d = (state_d == S_DSTART);
    rdy_d    = (state_d == S_DONE);
    busy_d   = (state_d == S_MSTART) || (state_d == S_MRUN) ||
               (state_d == S_DSTART) || (state_d == S_DRUN);
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      wdog_q   <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
      mstart_q <= 1'b0;
      dstart_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      wdog_q   <= wdog_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
      busy_q   <= busy_d;
      mstart_q <= mstart_d;
      dstart_q <= dstart_d;
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign busy           = busy_q;
  assign mult_start     = mstart_q;
  assign div_start      = dstart_q;
  assign mult_A         = a_q;
  assign mult_B         = b_q;
  assign div_dividend   = a_q;
  assign div_divisor    = b_q;

endmodule
